// File: rtl/mod6_counter_sequencer.sv
// -----------------------------------------------------------------------------
// mod6_counter_sequencer
//
// Command-driven controller for a mod-6 T-flip-flop up/down counter. It accepts
// LOAD/UP/DOWN/CLEAR commands over a valid/ready handshake and is the only
// driver of the counter's enable, reverse, set[4:1] and reset[4:1] pins. It
// tracks the count the counter should hold and compares it against the
// counter's Q once every command finishes.
//
// Ports
//   clk          in   1       system clock, rising edge
//   reset        in   1       synchronous active-high reset of this controller
//   cmd_valid    in   1       command present
//   cmd_ready    out  1       command can be accepted (IDLE only)
//   cmd_op       in   2       00 LOAD, 01 UP, 10 DOWN, 11 CLEAR
//   cmd_arg      in   STEP_W  LOAD: target value, UP/DOWN: step count
//   cnt_q        in   4       counter Q[4:1] (Q[4] is always 0)
//   cnt_enable   out  1       counter enable
//   cnt_reverse  out  1       counter direction, 1 = count down
//   cnt_set      out  4       counter per-bit set
//   cnt_reset    out  4       counter per-bit reset
//   busy         out  1       command in progress
//   done         out  1       one-cycle pulse: command finished and Q matched
//   err          out  1       one-cycle pulse: illegal command or Q mismatch
//   expected     out  3       tracked count value
//   wrap_cnt     out  8       (WRAP_COUNT_EN only) saturating count of wraps
//
// Build option: define WRAP_COUNT_EN to add the wrap_cnt output and its logic.
// -----------------------------------------------------------------------------
module mod6_counter_sequencer #(
    parameter int MODULUS = 6,
    parameter int STEP_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_arg,
    input  logic [3:0]        cnt_q,
    output logic              cnt_enable,
    output logic              cnt_reverse,
    output logic [3:0]        cnt_set,
    output logic [3:0]        cnt_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        expected
`ifdef WRAP_COUNT_EN
    ,
    output logic [7:0]        wrap_cnt
`endif
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [2:0]        MAX_VAL = 3'(MODULUS - 1);
    localparam logic [STEP_W-1:0] MOD_ARG = STEP_W'(MODULUS);

    // REJECT is the one-cycle slot in which an illegal command reports err.
    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_FORCE  = 3'd1,
        ST_STEP   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_IDLE   = 3'd4,
        ST_REJECT = 3'd5
    } state_t;

    state_t            state_q,    state_d;
    logic [2:0]        tgt_q,      tgt_d;
    logic [STEP_W-1:0] rem_q,      rem_d;
    logic              down_q,     down_d;
    logic [2:0]        exp_q,      exp_d;
    logic              ready_q,    ready_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;
    logic              enable_q,   enable_d;
    logic              reverse_q,  reverse_d;
    logic [3:0]        set_q,      set_d;
    logic [3:0]        rst_q,      rst_d;
`ifdef WRAP_COUNT_EN
    logic [7:0]        wrap_q,     wrap_d;
`endif

    // Next count modulo MODULUS in the given direction.
    function automatic logic [2:0] step_val(input logic [2:0] v, input logic dn);
        logic [2:0] r;
        if (dn) begin
            r = (v == 3'd0) ? MAX_VAL : (v - 3'd1);
        end else begin
            r = (v == MAX_VAL) ? 3'd0 : (v + 3'd1);
        end
        return r;
    endfunction

    // True when stepping from v in the given direction crosses the modulus boundary.
    function automatic logic step_wraps(input logic [2:0] v, input logic dn);
        return dn ? (v == 3'd0) : (v == MAX_VAL);
    endfunction

    // Next-state and next-output computation for the whole controller.
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        rem_d     = rem_q;
        down_d    = down_q;
        exp_d     = exp_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        enable_d  = 1'b0;
        reverse_d = 1'b0;
        set_d     = 4'b0000;
        rst_d     = 4'b0000;
`ifdef WRAP_COUNT_EN
        wrap_d    = wrap_q;
`endif
        case (state_q)
            // Power-up acts as an internal CLEAR: force the counter to 0.
            ST_INIT: begin
                state_d = ST_FORCE;
                tgt_d   = 3'd0;
                rst_d   = 4'b0111;
                ready_d = 1'b0;
                busy_d  = 1'b1;
            end
            // The set/reset pattern is on the pins during this cycle.
            ST_FORCE: begin
                state_d = ST_CHECK;
                exp_d   = tgt_q;
            end
            // One counter step per cycle; expected follows in lock-step.
            ST_STEP: begin
                exp_d = step_val(exp_q, down_q);
`ifdef WRAP_COUNT_EN
                if (step_wraps(exp_q, down_q) && (wrap_q != 8'hFF)) begin
                    wrap_d = wrap_q + 8'd1;
                end else begin
                    wrap_d = wrap_q;
                end
`endif
                if (rem_q == STEP_W'(1)) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d   = ST_STEP;
                    rem_d     = rem_q - STEP_W'(1);
                    enable_d  = 1'b1;
                    reverse_d = down_q;
                end
            end
            // Counter pins idle; compare Q against the tracked value.
            ST_CHECK: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (cnt_q == {1'b0, exp_q}) begin
                    done_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            ST_REJECT: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                err_d   = 1'b1;
            end
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    case (cmd_op)
                        OP_LOAD: begin
                            if (cmd_arg >= MOD_ARG) begin
                                state_d = ST_REJECT;
                            end else begin
                                state_d = ST_FORCE;
                                tgt_d   = cmd_arg[2:0];
                                set_d   = {1'b0, cmd_arg[2:0]};
                                rst_d   = {1'b0, ~cmd_arg[2:0]};
                            end
                        end
                        OP_CLEAR: begin
                            state_d = ST_FORCE;
                            tgt_d   = 3'd0;
                            rst_d   = 4'b0111;
                        end
                        OP_UP, OP_DOWN: begin
                            if (cmd_arg == '0) begin
                                state_d = ST_REJECT;
                            end else begin
                                state_d   = ST_STEP;
                                rem_d     = cmd_arg;
                                down_d    = (cmd_op == OP_DOWN);
                                enable_d  = 1'b1;
                                reverse_d = (cmd_op == OP_DOWN);
                            end
                        end
                        default: begin
                            state_d = ST_REJECT;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
                ready_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Controller state and registered outputs; reset aborts any command.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_INIT;
            tgt_q     <= 3'd0;
            rem_q     <= '0;
            down_q    <= 1'b0;
            exp_q     <= 3'd0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            enable_q  <= 1'b0;
            reverse_q <= 1'b0;
            set_q     <= 4'b0000;
            rst_q     <= 4'b0000;
`ifdef WRAP_COUNT_EN
            wrap_q    <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            rem_q     <= rem_d;
            down_q    <= down_d;
            exp_q     <= exp_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            enable_q  <= enable_d;
            reverse_q <= reverse_d;
            set_q     <= set_d;
            rst_q     <= rst_d;
`ifdef WRAP_COUNT_EN
            wrap_q    <= wrap_d;
`endif
        end
    end

    assign cmd_ready   = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign expected    = exp_q;
    assign cnt_enable  = enable_q;
    assign cnt_reverse = reverse_q;
    assign cnt_set     = set_q;
    assign cnt_reset   = rst_q;
`ifdef WRAP_COUNT_EN
    assign wrap_cnt    = wrap_q;
`endif

endmodule

// File: tb/tb_mod6_counter_sequencer.sv
module tb_mod6_counter_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_arg;
    logic [3:0] cnt_q;
    logic       cnt_enable;
    logic       cnt_reverse;
    logic [3:0] cnt_set;
    logic [3:0] cnt_reset;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] expected;
`ifdef WRAP_COUNT_EN
    logic [7:0] wrap_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Counter model: per-bit set/reset dominate, otherwise mod-6 count when enabled.
    logic [2:0] mq    = 3'd3;
    logic       stuck = 1'b0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (stuck) begin
            mq <= 3'd2;
        end else if ((|cnt_set[2:0]) || (|cnt_reset[2:0])) begin
            mq <= (mq | cnt_set[2:0]) & ~cnt_reset[2:0];
        end else if (cnt_enable) begin
            if (cnt_reverse) mq <= (mq == 3'd0) ? 3'd5 : mq - 3'd1;
            else             mq <= (mq == 3'd5) ? 3'd0 : mq + 3'd1;
        end
    end
    assign cnt_q = {1'b0, mq};

    mod6_counter_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_arg     (cmd_arg),
        .cnt_q       (cnt_q),
        .cnt_enable  (cnt_enable),
        .cnt_reverse (cnt_reverse),
        .cnt_set     (cnt_set),
        .cnt_reset   (cnt_reset),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .expected    (expected)
`ifdef WRAP_COUNT_EN
        ,
        .wrap_cnt    (wrap_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Present one command for a single edge (accepted only if the DUT is IDLE).
    task automatic send(input logic [1:0] op, input logic [3:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_arg   = 4'd0;
        tick();
        tick();

        // 1: reset state, then INIT clears the counter
        check("rst_ready",    cmd_ready, 0);
        check("rst_busy",     busy, 0);
        check("rst_done",     done, 0);
        check("rst_err",      err, 0);
        check("rst_expected", expected, 0);
        check("rst_enable",   cnt_enable, 0);
        check("rst_cnt_rst",  cnt_reset, 0);
        reset = 1'b0;
        tick();
        check("init_cnt_rst", cnt_reset, 4'b0111);
        check("init_cnt_set", cnt_set, 0);
        check("init_busy",    busy, 1);
        tick();
        check("init_rst_1cyc", cnt_reset, 0);
        tick();
        check("init_done",     done, 1);
        check("init_err",      err, 0);
        check("init_ready",    cmd_ready, 1);
        check("init_expected", expected, 0);

        // 2: LOAD 4
        send(2'b00, 4'd4);
        check("ld4_set",   cnt_set, 4'b0100);
        check("ld4_rst",   cnt_reset, 4'b0011);
        check("ld4_ready", cmd_ready, 0);
        tick();
        check("ld4_set_off", cnt_set, 0);
        check("ld4_no_done_early", done, 0);
        tick();
        check("ld4_done",     done, 1);
        check("ld4_expected", expected, 4);

        // 3: LOAD 3, UP 5 -> 2 with one wrap
        send(2'b00, 4'd3);
        tick();
        tick();
        check("ld3_done", done, 1);
        send(2'b01, 4'd5);
        for (int i = 0; i < 5; i++) begin
            check("up5_enable",  cnt_enable, 1);
            check("up5_reverse", cnt_reverse, 0);
            tick();
        end
        check("up5_enable_off", cnt_enable, 0);
        check("up5_no_done_early", done, 0);
        tick();
        check("up5_done",     done, 1);
        check("up5_expected", expected, 2);
`ifdef WRAP_COUNT_EN
        check("up5_wrap", wrap_cnt, 1);
`endif

        // 4: LOAD 1, DOWN 3 with cmd_valid held through busy -> 4
        send(2'b00, 4'd1);
        tick();
        tick();
        check("ld1_done", done, 1);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_arg   = 4'd3;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("dn3_enable",  cnt_enable, 1);
            check("dn3_reverse", cnt_reverse, 1);
            check("dn3_ready",   cmd_ready, 0);
            tick();
        end
        check("dn3_enable_off", cnt_enable, 0);
        tick();
        cmd_valid = 1'b0;
        check("dn3_done",     done, 1);
        check("dn3_expected", expected, 4);
`ifdef WRAP_COUNT_EN
        check("dn3_wrap", wrap_cnt, 2);
`endif
        tick();
        check("dn3_no_reaccept", cnt_enable, 0);
        check("dn3_idle_ready",  cmd_ready, 1);
        check("dn3_hold_exp",    expected, 4);

        // 5: illegal LOAD 7 and UP 0
        send(2'b00, 4'd7);
        check("ld7_set",    cnt_set, 0);
        check("ld7_rst",    cnt_reset, 0);
        check("ld7_enable", cnt_enable, 0);
        tick();
        check("ld7_err",      err, 1);
        check("ld7_done",     done, 0);
        check("ld7_expected", expected, 4);
        check("ld7_ready",    cmd_ready, 1);
        send(2'b01, 4'd0);
        check("up0_enable", cnt_enable, 0);
        check("up0_set",    cnt_set, 0);
        tick();
        check("up0_err",      err, 1);
        check("up0_done",     done, 0);
        check("up0_expected", expected, 4);

        // 6: stuck counter gives CHECK mismatch, then reset mid-STEP
        stuck = 1'b1;
        send(2'b00, 4'd5);
        tick();
        tick();
        check("stuck_err",      err, 1);
        check("stuck_done",     done, 0);
        check("stuck_expected", expected, 5);
        stuck = 1'b0;
        send(2'b01, 4'd4);
        tick();
        check("mid_enable", cnt_enable, 1);
        reset = 1'b1;
        tick();
        check("abort_enable",   cnt_enable, 0);
        check("abort_ready",    cmd_ready, 0);
        check("abort_expected", expected, 0);
        reset = 1'b0;
        tick();
        check("reinit_cnt_rst", cnt_reset, 4'b0111);
        tick();
        tick();
        check("reinit_done",     done, 1);
        check("reinit_expected", expected, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
